// File: rtl/master_alu_unit.sv
// Registered 32-bit ARM-style execute unit: conditional ALU, NZCV flags, LDR/STR strobe.
// Define MASTER_ALU_MUL_EN to give OpCode A a signed 32x32 multiply (otherwise a NOP).
module master_alu_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic signed [WIDTH-1:0] Reg1,
  input  logic signed [WIDTH-1:0] Reg2,
  input  logic [SHAMT_W-1:0]      IV_ShftRor,
  input  logic [15:0]             IV_Mov,
  input  logic [3:0]              OpCode,
  input  logic [3:0]              Cond,
  input  logic                    S,
  input  logic [3:0]              Flag,
  output logic signed [WIDTH-1:0] Result,
  output logic [3:0]              New_Flag,
  output logic                    memory_enable
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_ORR = 4'h3,
    OP_EOR = 4'h4, OP_MOV = 4'h5, OP_LSL = 4'h6, OP_LSR = 4'h7,
    OP_ROR = 4'h8, OP_CMP = 4'h9, OP_MUL = 4'hA, OP_MVN = 4'hB,
    OP_LDR = 4'hC, OP_STR = 4'hD, OP_NP0 = 4'hE, OP_NP1 = 4'hF
  } op_e;

  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flag;
  logic             r_mem;

  logic             w_n, w_z, w_c, w_v;
  logic             w_pass;
  logic [WIDTH-1:0] w_a, w_b, w_imm;
  logic [WIDTH:0]   w_sum, w_diff, w_lsl_ext, w_lsr_ext;
  logic [WIDTH-1:0] w_ror;
  logic             w_add_v, w_sub_v, w_sh_zero;
  logic [WIDTH-1:0] w_val;
  logic             w_wr, w_fl_op, w_cmp, w_mem;
  logic             w_c_new, w_v_new;
  logic [3:0]       w_nf;
`ifdef MASTER_ALU_MUL_EN
  logic [WIDTH-1:0] w_mul;
`endif

  assign {w_n, w_z, w_c, w_v} = Flag;

  always_comb begin
    w_pass = 1'b0;
    unique case (Cond)
      4'h0: w_pass = w_z;
      4'h1: w_pass = !w_z;
      4'h2: w_pass = w_c;
      4'h3: w_pass = !w_c;
      4'h4: w_pass = w_n;
      4'h5: w_pass = !w_n;
      4'h6: w_pass = w_v;
      4'h7: w_pass = !w_v;
      4'h8: w_pass = w_c && !w_z;
      4'h9: w_pass = !w_c || w_z;
      4'hA: w_pass = (w_n == w_v);
      4'hB: w_pass = (w_n != w_v);
      4'hC: w_pass = !w_z && (w_n == w_v);
      4'hD: w_pass = w_z || (w_n != w_v);
      4'hE: w_pass = 1'b1;
      4'hF: w_pass = 1'b0;
    endcase
  end

  assign w_a   = Reg1;
  assign w_b   = Reg2;
  assign w_imm = {{(WIDTH-16){1'b0}}, IV_Mov};

  // Extra bit on each side captures carry / not-borrow / last bit shifted out.
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff    = {1'b0, w_a} - {1'b0, w_b};
  assign w_lsl_ext = {1'b0, w_a} << IV_ShftRor;
  assign w_lsr_ext = {w_a, 1'b0} >> IV_ShftRor;
  assign w_ror     = (w_a >> IV_ShftRor)
                   | (w_a << (6'(WIDTH) - {1'b0, IV_ShftRor}));
  assign w_sh_zero = (IV_ShftRor == '0);

  assign w_add_v = (w_a[WIDTH-1] == w_b[WIDTH-1])
                && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  assign w_sub_v = (w_a[WIDTH-1] != w_b[WIDTH-1])
                && (w_diff[WIDTH-1] != w_a[WIDTH-1]);

`ifdef MASTER_ALU_MUL_EN
  assign w_mul = Reg1 * Reg2;
`endif

  always_comb begin
    w_val   = r_result;
    w_wr    = 1'b0;
    w_fl_op = 1'b0;
    w_cmp   = 1'b0;
    w_mem   = 1'b0;
    w_c_new = w_c;
    w_v_new = w_v;
    unique case (op_e'(OpCode))
      OP_ADD: begin
        w_val = w_sum[WIDTH-1:0];
        w_wr = 1'b1; w_fl_op = 1'b1;
        w_c_new = w_sum[WIDTH];
        w_v_new = w_add_v;
      end
      OP_SUB, OP_CMP: begin
        w_val = w_diff[WIDTH-1:0];
        w_wr = (OpCode == OP_SUB);
        w_cmp = (OpCode == OP_CMP);
        w_fl_op = 1'b1;
        w_c_new = !w_diff[WIDTH];
        w_v_new = w_sub_v;
      end
      OP_AND: begin
        w_val = w_a & w_b; w_wr = 1'b1; w_fl_op = 1'b1;
      end
      OP_ORR: begin
        w_val = w_a | w_b; w_wr = 1'b1; w_fl_op = 1'b1;
      end
      OP_EOR: begin
        w_val = w_a ^ w_b; w_wr = 1'b1; w_fl_op = 1'b1;
      end
      OP_MOV: begin
        w_val = w_imm; w_wr = 1'b1; w_fl_op = 1'b1;
      end
      OP_MVN: begin
        w_val = ~w_b; w_wr = 1'b1; w_fl_op = 1'b1;
      end
      OP_LSL: begin
        w_val = w_lsl_ext[WIDTH-1:0];
        w_wr = 1'b1; w_fl_op = 1'b1;
        w_c_new = w_sh_zero ? w_c : w_lsl_ext[WIDTH];
      end
      OP_LSR: begin
        w_val = w_lsr_ext[WIDTH:1];
        w_wr = 1'b1; w_fl_op = 1'b1;
        w_c_new = w_sh_zero ? w_c : w_lsr_ext[0];
      end
      OP_ROR: begin
        w_val = w_sh_zero ? w_a : w_ror;
        w_wr = 1'b1; w_fl_op = 1'b1;
        w_c_new = w_sh_zero ? w_c : w_ror[WIDTH-1];
      end
`ifdef MASTER_ALU_MUL_EN
      OP_MUL: begin
        w_val = w_mul; w_wr = 1'b1; w_fl_op = 1'b1;
      end
`endif
      OP_LDR, OP_STR: begin
        w_val = w_a + w_imm;
        w_wr = 1'b1; w_mem = 1'b1;
      end
      default: begin
        w_val = r_result;
      end
    endcase
  end

  assign w_nf = {w_val[WIDTH-1], (w_val == '0), w_c_new, w_v_new};

  // Failed condition: result holds, flags pass through, no strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_result <= '0;
      r_flag   <= '0;
      r_mem    <= 1'b0;
    end else begin
      r_flag <= Flag;
      r_mem  <= 1'b0;
      if (w_pass) begin
        if (w_wr)
          r_result <= w_val;
        if ((S && w_fl_op) || w_cmp)
          r_flag <= w_nf;
        r_mem <= w_mem;
      end
    end
  end

  assign Result        = r_result;
  assign New_Flag      = r_flag;
  assign memory_enable = r_mem;

endmodule

// File: tb/tb_master_alu_unit.sv
// Randomized self-checking bench for master_alu_unit against a behavioural model.
// Define MASTER_ALU_MUL_EN here as well as in the DUT to exercise multiply.
module tb_master_alu_unit;

  logic               Clk = 1'b0;
  logic               Reset;
  logic signed [31:0] Reg1, Reg2;
  logic [4:0]         IV_ShftRor;
  logic [15:0]        IV_Mov;
  logic [3:0]         OpCode, Cond, Flag;
  logic               S;
  logic signed [31:0] Result;
  logic [3:0]         New_Flag;
  logic               memory_enable;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] e_res  = '0;
  logic [3:0]  e_flag = '0;
  logic        e_mem  = 1'b0;

  master_alu_unit dut (
    .Clk(Clk), .Reset(Reset), .Reg1(Reg1), .Reg2(Reg2),
    .IV_ShftRor(IV_ShftRor), .IV_Mov(IV_Mov), .OpCode(OpCode),
    .Cond(Cond), .S(S), .Flag(Flag), .Result(Result),
    .New_Flag(New_Flag), .memory_enable(memory_enable)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ovf(input longint x);
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  // Expected state after the coming edge, from the current inputs.
  task automatic predict();
    longint unsigned ua, ub, wide;
    longint sa, sb;
    logic [31:0] r;
    bit c, v, wr, fl, cmp, mem;
    int n;
    if (Reset) begin
      e_res = '0; e_flag = '0; e_mem = 1'b0;
      return;
    end
    e_mem = 1'b0;
    e_flag = Flag;
    if (!cond_ok(Cond, Flag)) return;
    ua = longint'(unsigned'(Reg1));
    ub = longint'(unsigned'(Reg2));
    sa = longint'(Reg1);
    sb = longint'(Reg2);
    n = int'(IV_ShftRor);
    c = Flag[1]; v = Flag[0];
    wr = 1; fl = 1; cmp = 0; mem = 0;
    r = e_res;
    case (OpCode)
      4'h0: begin
        wide = ua + ub; r = wide[31:0];
        c = wide > 64'hFFFF_FFFF; v = ovf(sa + sb);
      end
      4'h1, 4'h9: begin
        wide = ua - ub; r = wide[31:0];
        c = ua >= ub; v = ovf(sa - sb);
        if (OpCode == 4'h9) begin wr = 0; cmp = 1; end
      end
      4'h2: r = Reg1 & Reg2;
      4'h3: r = Reg1 | Reg2;
      4'h4: r = Reg1 ^ Reg2;
      4'h5: r = {16'h0, IV_Mov};
      4'hB: r = ~Reg2;
      4'h6: begin
        wide = ua << n; r = wide[31:0];
        if (n != 0) c = wide[32];
      end
      4'h7: begin
        r = 32'(ua >> n);
        if (n != 0) c = ua[n-1];
      end
      4'h8: begin
        if (n == 0) r = Reg1;
        else begin
          r = 32'((ua >> n) | (ua << (32 - n)));
          c = ua[n-1];
        end
      end
`ifdef MASTER_ALU_MUL_EN
      4'hA: begin
        wide = longint'(sa * sb); r = wide[31:0];
      end
`endif
      4'hC, 4'hD: begin
        r = 32'(ua + longint'(IV_Mov)); fl = 0; mem = 1;
      end
      default: begin wr = 0; fl = 0; end
    endcase
    if (wr) e_res = r;
    if ((fl && S) || cmp) e_flag = {r[31], r == 0, c, v};
    e_mem = mem;
  endtask

  task automatic step(input string tag);
    predict();
    @(posedge Clk);
    #1;
    chk({tag, ".res"}, Result, e_res);
    chk({tag, ".flg"}, 32'(New_Flag), 32'(e_flag));
    chk({tag, ".mem"}, 32'(memory_enable), 32'(e_mem));
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] op,
                       input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [15:0] mv, input logic [3:0] f);
    Reset = 0; Cond = c; OpCode = op; S = s; Reg1 = a; Reg2 = b;
    IV_ShftRor = sh; IV_Mov = mv; Flag = f;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      4: return 32'(unsigned'($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drive(4'hE, 4'h0, 1, 32'h1234, 32'h1, 5'd0, 16'h0, 4'h0);
    Reset = 1;
    step("rst0");
    chk("rst0.zero", Result, 32'h0);

    drive(4'hE, 4'h0, 1, 32'h7FFF_FFFF, 32'h1, 5'd0, 16'h0, 4'h0);
    step("add_ovf");
    chk("add_ovf.c", Result, 32'h8000_0000);
    chk("add_ovf.fc", 32'(New_Flag), 32'h9);

    drive(4'hE, 4'h9, 0, 32'd5, 32'd5, 5'd0, 16'h0, 4'h0);
    step("cmp_eq");
    chk("cmp_eq.c", 32'(New_Flag), 32'h6);
    chk("cmp_eq.hold", Result, 32'h8000_0000);

    drive(4'h0, 4'h5, 0, 32'h0, 32'h0, 5'd0, 16'hAAA3, 4'h6);
    step("mov_eq");
    chk("mov_eq.c", Result, 32'h0000_AAA3);

    drive(4'h1, 4'h0, 1, 32'h10, 32'h20, 5'd0, 16'h0, 4'h4);
    step("ne_fail");
    chk("ne_fail.c", Result, 32'h0000_AAA3);

    drive(4'hE, 4'hC, 1, 32'd2, 32'd9, 5'd0, 16'd5, 4'h3);
    step("ldr");
    chk("ldr.c", Result, 32'd7);
    chk("ldr.mem", 32'(memory_enable), 32'd1);
    drive(4'hE, 4'hE, 1, 32'd2, 32'd9, 5'd0, 16'd5, 4'h3);
    step("nop");
    chk("nop.mem", 32'(memory_enable), 32'd0);

    drive(4'hE, 4'h8, 1, 32'h1, 32'h0, 5'd1, 16'h0, 4'h0);
    step("ror1");
    chk("ror1.c", Result, 32'h8000_0000);
    chk("ror1.f", 32'(New_Flag), 32'hA);

    drive(4'hE, 4'h6, 1, 32'h8000_0001, 32'h0, 5'd0, 16'h0, 4'h2);
    step("lsl0");
    drive(4'hE, 4'h6, 1, 32'h8000_0001, 32'h0, 5'd31, 16'h0, 4'h0);
    step("lsl31");
    drive(4'hE, 4'h7, 1, 32'h8000_0001, 32'h0, 5'd1, 16'h0, 4'h0);
    step("lsr1");
    drive(4'hE, 4'h1, 1, 32'd3, 32'd5, 5'd0, 16'h0, 4'h0);
    step("sub_brw");
    drive(4'hE, 4'hF, 1, 32'd3, 32'd5, 5'd0, 16'h0, 4'hF);
    step("nv");
    drive(4'hE, 4'hA, 1, -32'sd3, 32'sd4, 5'd0, 16'h0, 4'h0);
    step("mul");

    drive(4'hE, 4'h0, 0, 32'h1, 32'h1, 5'd0, 16'h0, 4'h0);
    Reset = 1;
    step("rst1");

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom),
            4'($urandom), 1'($urandom), pick(), pick(),
            5'($urandom), 16'($urandom), 4'($urandom));
      Reset = ($urandom_range(0, 39) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
